// File: rtl/icache_assoc_pkg.sv
// Shared constants and address-split helpers for the set-associative instruction cache.
// The helpers take the field widths as arguments so any cache geometry can reuse them.
package icache_assoc_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    function automatic logic [31:0] low_mask(input int bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    function automatic logic [31:0] addr_boff(input logic [31:0] addr, input int boff_bits);
        return (addr >> 2) & low_mask(boff_bits);
    endfunction

    function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int boff_bits,
                                             input int idx_bits);
        return (addr >> (2 + boff_bits)) & low_mask(idx_bits);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int boff_bits,
                                             input int idx_bits);
        return addr >> (2 + boff_bits + idx_bits);
    endfunction

endpackage

// File: rtl/icache_lru.sv
// Per-set true-LRU age tracking and victim selection (lowest invalid way first, else oldest).
// Ages within a set always form a permutation of 0..WAYS-1.
module icache_lru #(
    parameter int SETS = 8,
    parameter int WAYS = 2,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [WAYS-1:0]  set_valid,
    input  logic             touch_en,
    input  logic [WAY_W-1:0] touch_way,
    input  logic             flush,
    output logic [WAY_W-1:0] victim
);

    localparam int AGE_W = WAY_W;

    logic [AGE_W-1:0] age_r [SETS][WAYS];
    logic [AGE_W-1:0] touched_age_s;
    logic [AGE_W-1:0] max_age_s;
    logic [WAY_W-1:0] first_invalid_s;
    logic [WAY_W-1:0] oldest_s;
    logic             any_invalid_s;
    logic             older_s;

    assign touched_age_s = age_r[set_idx][touch_way];

    // Victim pick: scan downwards so the lowest-numbered invalid way wins, else the oldest way
    always_comb begin
        any_invalid_s   = 1'b0;
        first_invalid_s = '0;
        oldest_s        = '0;
        max_age_s       = age_r[set_idx][0];
        older_s         = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            any_invalid_s   = any_invalid_s | ~set_valid[w];
            first_invalid_s = set_valid[w] ? first_invalid_s : WAY_W'(w);
        end
        for (int w = 1; w < WAYS; w++) begin
            older_s   = age_r[set_idx][w] > max_age_s;
            oldest_s  = older_s ? WAY_W'(w) : oldest_s;
            max_age_s = older_s ? age_r[set_idx][w] : max_age_s;
        end
        victim = any_invalid_s ? first_invalid_s : oldest_s;
    end

    // Age update: touched way becomes youngest, ways younger than it age by one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_r[s][w] <= AGE_W'(w);
                end
            end
        end else if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touch_way) begin
                    age_r[set_idx][w] <= '0;
                end else if (age_r[set_idx][w] < touched_age_s) begin
                    age_r[set_idx][w] <= age_r[set_idx][w] + AGE_W'(1);
                end else begin
                    age_r[set_idx][w] <= age_r[set_idx][w];
                end
            end
        end else begin
            age_r <= age_r;
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word blocks, true-LRU replacement,
// a committed block-fill FSM, synchronous flush and saturating hit/miss counters.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int SETS        = 8,
    parameter int WAYS        = 2,
    parameter int BLOCK_WORDS = 2,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    input  logic             iflush,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int BOFF   = $clog2(BLOCK_WORDS);
    localparam int IDX    = $clog2(SETS);
    localparam int TAG_W  = 30 - BOFF - IDX;
    localparam int BOFF_W = (BOFF > 0) ? BOFF : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic             valid_r    [SETS][WAYS];
    logic [TAG_W-1:0] line_tag_r [SETS][WAYS];
    logic [31:0]      data_r     [SETS][WAYS][BLOCK_WORDS];

    logic [0:0]        state_r;
    logic [31:0]       fill_base_r;
    logic [IDX-1:0]    fill_idx_r;
    logic [TAG_W-1:0]  fill_tag_r;
    logic [WAY_W-1:0]  fill_way_r;
    logic [BOFF_W-1:0] fill_cnt_r;
    logic [CNT_W-1:0]  hit_count_r;
    logic [CNT_W-1:0]  miss_count_r;

    logic [TAG_W-1:0]  tag_s;
    logic [IDX-1:0]    idx_s;
    logic [BOFF_W-1:0] boff_s;
    logic              hit_any_s;
    logic [WAY_W-1:0]  hit_way_s;
    logic              ihit_s;
    logic              miss_s;
    logic              beat_s;
    logic              commit_s;
    logic [IDX-1:0]    lru_set_s;
    logic [WAYS-1:0]   set_valid_s;
    logic [WAY_W-1:0]  touch_way_s;
    logic [WAY_W-1:0]  victim_s;

    assign tag_s  = TAG_W'(addr_tag(imemaddr, BOFF, IDX));
    assign idx_s  = IDX'(addr_idx(imemaddr, BOFF, IDX));
    assign boff_s = BOFF_W'(addr_boff(imemaddr, BOFF));

    // Tag match across the ways of the addressed set; at most one way can match
    always_comb begin
        hit_any_s = 1'b0;
        hit_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_any_s = hit_any_s | (valid_r[idx_s][w] && (line_tag_r[idx_s][w] == tag_s));
            hit_way_s = hit_way_s | ((valid_r[idx_s][w] && (line_tag_r[idx_s][w] == tag_s))
                                     ? WAY_W'(w) : WAY_W'(0));
        end
    end

    assign ihit_s   = imemREN && (state_r == ST_IDLE) && !iflush && hit_any_s;
    assign miss_s   = imemREN && (state_r == ST_IDLE) && !iflush && !hit_any_s;
    assign beat_s   = (state_r == ST_FILL) && !iflush && !iwait;
    assign commit_s = beat_s && (fill_cnt_r == BOFF_W'(BLOCK_WORDS - 1));

    assign ihit     = ihit_s;
    assign imemload = data_r[idx_s][hit_way_s][boff_s];
    assign iREN     = (state_r == ST_FILL);
    assign iaddr    = (state_r == ST_FILL) ? (fill_base_r + 32'({fill_cnt_r, 2'b00}))
                                           : {imemaddr[31:2], 2'b00};

    // During a fill the LRU looks at the latched set, otherwise at the fetch set
    always_comb begin
        lru_set_s   = (state_r == ST_FILL) ? fill_idx_r : idx_s;
        touch_way_s = (state_r == ST_FILL) ? fill_way_r : hit_way_s;
        set_valid_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid_s[w] = valid_r[lru_set_s][w];
        end
    end

    icache_lru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_lru (
        .clk       (CLK),
        .rst_n     (nRST),
        .set_idx   (lru_set_s),
        .set_valid (set_valid_s),
        .touch_en  (ihit_s || commit_s),
        .touch_way (touch_way_s),
        .flush     (iflush),
        .victim    (victim_s)
    );

    // Fill FSM: latch the miss context, count accepted beats, flush aborts
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r     <= ST_IDLE;
            fill_base_r <= 32'd0;
            fill_idx_r  <= '0;
            fill_tag_r  <= '0;
            fill_way_r  <= '0;
            fill_cnt_r  <= '0;
        end else if (iflush) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (miss_s) begin
                        state_r     <= ST_FILL;
                        fill_base_r <= imemaddr & ~low_mask(BOFF + 2);
                        fill_idx_r  <= idx_s;
                        fill_tag_r  <= tag_s;
                        fill_way_r  <= victim_s;
                        fill_cnt_r  <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (!iwait) begin
                        fill_cnt_r <= fill_cnt_r + BOFF_W'(1);
                        state_r    <= commit_s ? ST_IDLE : ST_FILL;
                    end else begin
                        state_r <= ST_FILL;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Valid bits: victim invalidated on fill entry so a partial line can never hit
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST || iflush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_r[s][w] <= 1'b0;
                end
            end
        end else if (miss_s) begin
            valid_r[idx_s][victim_s] <= 1'b0;
        end else if (commit_s) begin
            valid_r[fill_idx_r][fill_way_r] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data storage need no reset: valid bits gate every read
    always_ff @(posedge CLK) begin
        if (beat_s) begin
            data_r[fill_idx_r][fill_way_r][fill_cnt_r] <= iload;
        end
        if (commit_s) begin
            line_tag_r[fill_idx_r][fill_way_r] <= fill_tag_r;
        end
    end

    // Saturating performance counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count_r  <= '0;
            miss_count_r <= '0;
        end else begin
            if (ihit_s && (hit_count_r != '1)) begin
                hit_count_r <= hit_count_r + CNT_W'(1);
            end else begin
                hit_count_r <= hit_count_r;
            end
            if (miss_s && (miss_count_r != '1)) begin
                miss_count_r <= miss_count_r + CNT_W'(1);
            end else begin
                miss_count_r <= miss_count_r;
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: fetches push the expected instruction word, a
// negedge monitor pops and compares on every ihit; memory is a stallable model.
module tb_icache_assoc;

    localparam int BW = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iflush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb_q [$];
    logic [31:0] acc_q [$];
    logic [31:0] exp_w;
    int          stall_cfg = 0;
    int          stall_cnt;
    logic        prev_stall;
    logic [31:0] prev_addr;

    always #5 CLK = ~CLK;

    icache_assoc #(
        .SETS        (8),
        .WAYS        (2),
        .BLOCK_WORDS (BW),
        .CNT_W       (32)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iflush     (iflush),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // memory: word at address A reads as {16'hC0DE, A[15:0]}, stall_cfg wait cycles per word
    assign iload = {16'hC0DE, iaddr[15:0]};
    assign iwait = iREN && (stall_cnt < stall_cfg);

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) stall_cnt <= 0;
        else if (iREN && iwait) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
    end

    // monitor: scoreboard pop on hit, accepted-beat log, address hold while stalled
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (ihit === 1'b1) begin
                checks = checks + 1;
                if (sb_q.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL unexpected_hit: imemload=%h with empty scoreboard", imemload);
                end else begin
                    exp_w = sb_q.pop_front();
                    if (imemload !== exp_w) begin
                        failures = failures + 1;
                        $display("FAIL imemload: got %h expected %h", imemload, exp_w);
                    end
                end
            end
            if (iREN && !iwait) acc_q.push_back(iaddr);
            if (prev_stall) begin
                checks = checks + 1;
                if (iaddr !== prev_addr) begin
                    failures = failures + 1;
                    $display("FAIL stall_addr_hold: got %h expected %h", iaddr, prev_addr);
                end
            end
            prev_stall <= iREN && iwait;
            prev_addr  <= iaddr;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // issue a fetch and hold it until ihit; exp_lat = cycles before the hit (0 = hit)
    task automatic fetch(input logic [31:0] a, input int exp_lat, input logic [31:0] exp_word);
        int lat;
        bit got;
        logic [31:0] base;
        @(posedge CLK);
        #1;
        acc_q.delete();
        sb_q.push_back(exp_word);
        imemaddr = a;
        imemREN  = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge CLK);
            if (ihit === 1'b1) got = 1'b1;
            else lat++;
        end
        if (!got) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL fetch_timeout: addr %h got no hit expected hit", a);
            sb_q.delete();
        end else begin
            check("latency", lat, exp_lat);
        end
        @(posedge CLK);
        #1;
        imemREN = 1'b0;
        if (exp_lat > 0) begin
            base = a & 32'hFFFF_FFF8;
            check("fill_beats", acc_q.size(), BW);
            for (int k = 0; k < BW && k < acc_q.size(); k++)
                check("fill_addr", acc_q[k], base + 32'(4 * k));
        end else begin
            check("hit_no_fill", acc_q.size(), 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b1; imemREN = 1'b0; iflush = 1'b0; imemaddr = 32'h0000_0123;
        #1 nRST = 1'b0;
        #3;
        check("rst_iren", iREN, 0);
        check("rst_ihit", ihit, 0);
        check("rst_iaddr", iaddr, 32'h0000_0120);
        check("rst_hits", hit_count, 0);
        check("rst_miss", miss_count, 0);
        @(posedge CLK); #1 nRST = 1'b1;

        // cold miss then zero-latency hit on the other word of the block
        fetch(32'h40, 3, 32'hC0DE_0040);
        fetch(32'h44, 0, 32'hC0DE_0044);
        check("cold_miss_cnt", miss_count, 1);
        check("cold_hit_cnt", hit_count, 2);

        // two tags share set 0 without eviction
        fetch(32'h440, 3, 32'hC0DE_0440);
        fetch(32'h40, 0, 32'hC0DE_0040);
        fetch(32'h444, 0, 32'hC0DE_0444);

        // LRU: touch 0x40, then 0x840 must evict 0x440
        fetch(32'h44, 0, 32'hC0DE_0044);
        fetch(32'h840, 3, 32'hC0DE_0840);
        fetch(32'h40, 0, 32'hC0DE_0040);
        fetch(32'h440, 3, 32'hC0DE_0440);
        check("lru_miss_cnt", miss_count, 4);
        check("lru_hit_cnt", hit_count, 9);

        // stalled memory: 3 wait cycles before each word
        stall_cfg = 3;
        fetch(32'hC0, 9, 32'hC0DE_00C0);
        stall_cfg = 0;

        // flush mid-fill
        fetch(32'h40, 3, 32'hC0DE_0040);
        @(posedge CLK); #1;
        imemaddr = 32'h80; imemREN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("fill_iren", iREN, 1);
        check("fill_iaddr0", iaddr, 32'h80);
        @(posedge CLK); #1 iflush = 1'b1;
        @(negedge CLK);
        check("flush_ihit", ihit, 0);
        @(posedge CLK); #1 iflush = 1'b0; imemREN = 1'b0;
        @(negedge CLK);
        check("flush_idle", iREN, 0);
        fetch(32'h80, 3, 32'hC0DE_0080);
        fetch(32'h40, 3, 32'hC0DE_0040);

        // flush in IDLE suppresses a would-be hit and starts no fill
        @(posedge CLK); #1;
        imemaddr = 32'h84; imemREN = 1'b1; iflush = 1'b1;
        @(negedge CLK);
        check("flush_idle_ihit", ihit, 0);
        @(posedge CLK); #1 iflush = 1'b0; imemREN = 1'b0;
        @(negedge CLK);
        check("flush_no_fill", iREN, 0);
        fetch(32'h84, 3, 32'hC0DE_0084);
        check("flush_miss_cnt", miss_count, 10);
        check("flush_hit_cnt", hit_count, 14);

        // reset mid-fill
        @(posedge CLK); #1;
        imemaddr = 32'h100; imemREN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("rfill_iren", iREN, 1);
        #2 nRST = 1'b0;
        #1;
        check("rfill_iren_drop", iREN, 0);
        check("rfill_hits", hit_count, 0);
        check("rfill_miss", miss_count, 0);
        imemREN = 1'b0;
        @(posedge CLK); #1 nRST = 1'b1;
        fetch(32'h80, 3, 32'hC0DE_0080);
        fetch(32'h40, 3, 32'hC0DE_0040);
        check("post_rst_miss", miss_count, 2);
        check("post_rst_hits", hit_count, 2);

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised set-associative instruction cache between the fetch stage and the memory controller.
- Multi-word blocks, per-set true-LRU replacement, a block-fill FSM and a synchronous flush.
- Replaces the single-word direct-mapped icache.
- Exposes hit/miss counters for the performance bench.

Parameters:
- SETS, 8, number of sets; power of two, >= 2.
- WAYS, 2, associativity; power of two, 1..8.
- BLOCK_WORDS, 2, 32-bit words per block; power of two, 1..8.
- CNT_W, 32, width of the hit/miss counters.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- imemREN  in  1  fetch request from datapath.
- imemaddr  in  32  byte address of fetch; bits [1:0] ignored.
- ihit  out  1  fetch served this cycle.
- imemload  out  32  instruction word; valid when ihit=1.
- iflush  in  1  invalidate all lines; single-cycle pulse.
- iREN  out  1  read request to memory controller.
- iaddr  out  32  word-aligned memory address.
- iwait  in  1  memory busy; iload valid when iREN=1 and iwait=0.
- iload  in  32  memory read data.
- hit_count  out  CNT_W  fetches served by hits; saturating.
- miss_count  out  CNT_W  fills started; saturating.

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous and active-low.
- Reset state:
  - All valid bits 0; LRU ages initialised so that way w has age w.
  - FSM in IDLE; counters 0; iREN=0; ihit=0.
  - iaddr=imemaddr with bits [1:0] forced to 0.
- Address split, LSB first:
  - 2 byte bits.
  - BOFF=log2(BLOCK_WORDS) block-offset bits.
  - IDX=log2(SETS) index bits.
  - Tag = the remaining 32-2-BOFF-IDX bits.
- Hit:
  - ihit=1 combinationally when all hold: imemREN=1, state is IDLE, iflush=0, and some valid way in set[IDX] has a matching tag.
  - imemload = that way's word[BOFF]. Zero-cycle latency.
  - At most one way can match; a multi-match is an assertion error.
- LRU (true LRU, age counters of log2(WAYS) bits per way):
  - Hit or completed fill makes the touched way age 0.
  - Ways younger than it age by 1; others are unchanged.
- Victim choice: the lowest-numbered invalid way in the set, else the way with maximum age.
- FSM states: IDLE, FILL.
  - IDLE -> FILL on a miss:
    - Condition: imemREN=1, no hit, iflush=0.
    - Latch block base address (offset bits cleared), index, tag and victim.
    - Clear word counter; increment miss_count.
  - FILL:
    - Drive iREN=1 and iaddr = latched base + 4*counter.
    - On each cycle with iwait=0, write iload into victim.word[counter] and increment counter.
    - On the beam of the last word: set victim valid, write tag, update LRU, return to IDLE.
  - The refetch hits the cycle after the fill completes.
  - Miss latency is BLOCK_WORDS accepted words plus 1 cycle.
  - Victim valid is cleared on FILL entry, so a partial line never hits.
- ihit=0 throughout FILL.
- A fill is committed once started:
  - imemREN dropping or imemaddr changing mid-fill does not abort it.
  - After the fill, IDLE re-evaluates the current imemaddr.
- iflush:
  - Clears every valid bit next edge and resets LRU ages.
  - In FILL it aborts the fill: the line stays invalid and the FSM returns to IDLE; the counter is not rolled back.
  - ihit is forced to 0 in the flush cycle.
  - A flush coinciding with a miss in IDLE does not start a fill.
- iREN=0 in IDLE; iaddr follows imemaddr in IDLE.
- Counters:
  - hit_count increments on every cycle with ihit=1.
  - Both counters hold at all-ones, with no wrap.
- Reset mid-fill: immediate return to reset state; iREN drops asynchronously.

Decomposition:
- The cpu_types_pkg extension holds:
  - The parametrised address-split helper functions (tag/idx/boff extraction).
  - The icache_state_t enum {IDLE, FILL}.
  - The icache_line_t struct template (valid, tag, word array) sized from package constants.
- One sub-module, icache_lru:
  - Per-set age arrays.
  - Victim select (invalid-first, then oldest).
  - Touch/update logic.
  - Inputs: set index, touch way, touch enable, flush. Output: victim way.

Test Plan:
- Cold miss (defaults):
  - Stimulus: fetch 0x00000040 with iwait=0 always.
  - iREN=1 with iaddr 0x40 then 0x44.
  - Cycle 3: ihit=1, imemload=word@0x40.
  - Then fetch 0x44: ihit=1 with zero latency; miss_count=1, hit_count=2.
- Associativity:
  - Fill 0x040 and 0x440 (same set 0, different tags).
  - Both then hit with no iREN; no eviction.
- LRU eviction:
  - Fill 0x040 and 0x440; hit 0x040; fetch 0x840.
  - The 0x440 way is replaced; 0x040 still hits; 0x440 misses.
- Stalled memory:
  - iwait=1 for 3 cycles before each word.
  - iaddr is held stable during the stall; ihit=0 until both words land.
  - Miss latency = 9 cycles.
- Flush mid-fill:
  - Pulse iflush after the first word of the 0x80 fill.
  - FSM returns to IDLE; the next fetch of 0x80 misses and refills fully.
  - Previously valid 0x40 also misses.
- Reset mid-fill:
  - Assert nRST=0 during FILL.
  - iREN=0 immediately; counters 0; all fetches then miss.
